k2_program_loader: RTL and testbench

//   Writer side of the K2 instruction-fetch interface: a loadable instruction

---
 rtl/k2_program_loader.sv | 77 +++++++
 tb/tb_k2_program_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/k2_program_loader.sv
// rtl/k2_program_loader.sv - loadable K2 instruction store with processor reset sequencing
module k2_program_loader #(
    parameter int ADDR_W         = 4,
    parameter int INST_W         = 8,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic                in_valid,
    input  logic [INST_W-1:0]   in_data,
    input  logic                in_last,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   ProgramAddress,
    output logic [INST_W-1:0]   instruction_data,
    output logic                cpu_rst_n,
    output logic                busy,
    output logic                load_done,
    output logic [ADDR_W:0]     word_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int RC_W  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;

    state_t              state, state_nxt;
    logic [INST_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wptr;
    logic [RC_W-1:0]     rel_cnt;
    logic                xfer;
    logic                last_word;

    assign xfer      = in_valid && (state == S_LOAD);
    // wptr is cleared on entry to LOAD, so wptr == DEPTH-1 marks the final-depth transfer
    assign last_word = in_last || (wptr == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (load_start) state_nxt = S_LOAD;
            S_LOAD:    if (xfer && last_word) state_nxt = S_RELEASE;
            S_RELEASE: if (rel_cnt == RC_W'(RELEASE_CYCLES - 1)) state_nxt = S_RUN;
            S_RUN:     if (load_start) state_nxt = S_LOAD;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wptr       <= '0;
            word_count <= '0;
            rel_cnt    <= '0;
            load_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state     <= state_nxt;
            load_done <= (state == S_RELEASE) && (state_nxt == S_RUN);
            rel_cnt   <= (state == S_RELEASE) ? rel_cnt + RC_W'(1) : '0;
            if ((state != S_LOAD) && (state_nxt == S_LOAD)) begin
                wptr       <= '0;
                word_count <= '0;
            end else if (xfer) begin
                mem[wptr] <= in_data;
                wptr      <= wptr + ADDR_W'(1);
                if (word_count != (ADDR_W + 1)'(DEPTH)) word_count <= word_count + (ADDR_W + 1)'(1);
            end
        end
    end

    // Combinational read matches the ROM it replaces; a same-cycle write is seen next cycle
    assign instruction_data = mem[ProgramAddress];
    assign in_ready         = (state == S_LOAD);
    assign busy             = (state == S_LOAD) || (state == S_RELEASE);
    assign cpu_rst_n        = (state == S_RUN);

endmodule

// File: tb/tb_k2_program_loader.sv
// tb/tb_k2_program_loader.sv - scoreboard bench for k2_program_loader
module tb_k2_program_loader;
    localparam int RELEASE_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [3:0] ProgramAddress = 4'h0;
    logic [7:0] instruction_data;
    logic       cpu_rst_n;
    logic       busy;
    logic       load_done;
    logic [4:0] word_count;

    k2_program_loader #(.ADDR_W(4), .INST_W(8), .RELEASE_CYCLES(RELEASE_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .ProgramAddress(ProgramAddress), .instruction_data(instruction_data),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .load_done(load_done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    kind;
        int    exp;
    } chk_t;

    chk_t cq[$];
    int   xq[$];
    int   dq[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   xfer_cyc = 0;
    int   nsent = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    // Monitor: drains queued status/read expectations, handshakes and load_done pulses
    always @(negedge clk) begin
        chk_t it;
        int   act;
        int   e;
        while (cq.size() > 0) begin
            it = cq.pop_front();
            case (it.kind)
                0:       act = int'(instruction_data);
                1:       act = int'(word_count);
                2:       act = int'(cpu_rst_n);
                3:       act = int'(in_ready);
                4:       act = int'(busy);
                5:       act = int'(load_done);
                6:       act = dq.size();
                default: act = xq.size();
            endcase
            compared++;
            if (act !== it.exp) begin
                mismatched++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", it.nm, act, it.exp);
            end
        end
        if (in_valid && in_ready) begin
            compared++;
            if (xq.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_xfer: got handshake with data 0x%0h expected none", in_data);
            end else begin
                e = xq.pop_front();
                if (int'(word_count) != e) begin
                    mismatched++;
                    $display("FAIL xfer_index: got %0d expected %0d", word_count, e);
                end
            end
            xfer_cyc = cyc + 1;
        end
        if (prev_done) begin
            compared++;
            if (load_done !== 1'b0) begin
                mismatched++;
                $display("FAIL done_width: got %0b expected 0", load_done);
            end
        end
        if (load_done === 1'b1) begin
            compared += 3;
            if (dq.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: got load_done expected none");
            end else begin
                e = dq.pop_front();
                if (int'(word_count) != e) begin
                    mismatched++;
                    $display("FAIL done_count: got %0d expected %0d", word_count, e);
                end
            end
            if (cyc - xfer_cyc != RELEASE_CYCLES) begin
                mismatched++;
                $display("FAIL release_delay: got %0d expected %0d", cyc - xfer_cyc, RELEASE_CYCLES);
            end
            if (cpu_rst_n !== 1'b1) begin
                mismatched++;
                $display("FAIL done_cpu_rst: got %0b expected 1", cpu_rst_n);
            end
        end
        prev_done = (load_done === 1'b1);
    end

    task automatic chk(input string nm, input int kind, input int addr, input int exp);
        ProgramAddress = 4'(addr);
        cq.push_back('{nm, kind, exp});
        @(negedge clk);
        #1;
    endtask

    task automatic start_load();
        @(posedge clk); #1;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        nsent = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        xq.push_back(nsent);
        nsent++;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stray_valid(input int n);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (n) @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu_rst_n !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("run_reached", 2, 0, 1);
    endtask

    initial begin
        // 1: reset, idle, stray in_valid in IDLE
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_cpu_rst", 2, 0, 0);
        chk("idle_in_ready", 3, 0, 0);
        chk("idle_busy", 4, 0, 0);
        chk("idle_count", 1, 0, 0);
        stray_valid(3);
        for (int a = 0; a < 16; a++) chk("reset_ram", 0, a, 8'h00);

        // 2: short program A1 B2 C3
        start_load();
        chk("load_in_ready", 3, 0, 1);
        chk("load_busy", 4, 0, 1);
        chk("load_cpu_rst", 2, 0, 0);
        dq.push_back(3);
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hC3, 1'b1);
        chk("release_in_ready", 3, 0, 0);
        chk("release_busy", 4, 0, 1);
        wait_run();
        chk("t2_count", 1, 0, 3);
        chk("t2_addr0", 0, 0, 8'hA1);
        chk("t2_addr1", 0, 1, 8'hB2);
        chk("t2_addr2", 0, 2, 8'hC3);
        chk("t2_addr3", 0, 3, 8'h00);
        chk("run_busy", 4, 0, 0);

        // 3: full-depth load with no in_last
        start_load();
        dq.push_back(16);
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        chk("full_in_ready", 3, 0, 0);
        wait_run();
        chk("full_count", 1, 0, 16);
        chk("full_addr15", 0, 15, 8'h0F);
        chk("full_addr0", 0, 0, 8'h00);
        chk("full_addr7", 0, 7, 8'h07);

        // 5: reload from RUN with a partial program
        start_load();
        chk("reload_cpu_rst", 2, 0, 0);
        chk("reload_count", 1, 0, 0);
        dq.push_back(2);
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        wait_run();
        chk("part_addr0", 0, 0, 8'h55);
        chk("part_addr1", 0, 1, 8'h66);
        chk("part_addr2", 0, 2, 8'h02);
        chk("part_addr15", 0, 15, 8'h0F);

        // 4: gaps mid-load, stray in_valid in RUN
        stray_valid(3);
        chk("stray_run_addr0", 0, 0, 8'h55);
        start_load();
        dq.push_back(3);
        send(8'h21, 1'b0);
        repeat (3) @(posedge clk);
        send(8'h22, 1'b0);
        repeat (2) @(posedge clk);
        send(8'h23, 1'b1);
        wait_run();
        stray_valid(2);
        chk("gap_count", 1, 0, 3);
        chk("gap_addr0", 0, 0, 8'h21);
        chk("gap_addr1", 0, 1, 8'h22);
        chk("gap_addr2", 0, 2, 8'h23);
        chk("gap_addr3", 0, 3, 8'h03);

        // 6: asynchronous reset after the second word of a load
        start_load();
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        #2 rst_n = 1'b0;
        chk("areset_in_ready", 3, 0, 0);
        chk("areset_busy", 4, 0, 0);
        chk("areset_cpu_rst", 2, 0, 0);
        chk("areset_count", 1, 0, 0);
        chk("areset_done", 5, 0, 0);
        for (int a = 0; a < 4; a++) chk("areset_ram", 0, a, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_in_ready", 3, 0, 0);

        chk("done_queue_empty", 6, 0, 0);
        chk("xfer_queue_empty", 7, 0, 0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
